hyp_req_scheduler: RTL and testbench
====================================

Name: hyp_req_scheduler

Overview:
- Shares one iterative hypotenuse engine, result = floor(sqrt(x^2+y^2)), between NUM_REQ requesters.
- Arbitrates requesters round-robin, latches the winner's operands and pulses the engine start.
- Waits for engine done, then returns the result tagged with the requester id over a valid/ready response channel.
- Sits between the tile's input muxing and the shared sqrt datapath; at most one operation is in flight.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDW, 2, requester id width; must satisfy 2^IDW >= NUM_REQ.
- DW, 8, operand width; result width is DW+1.
- TIMEOUT, 64, engine watchdog limit in cycles. Used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_x  in  NUM_REQ*DW  packed x operands; requester i uses bits [i*DW +: DW].
- req_y  in  NUM_REQ*DW  packed y operands, same packing as req_x.
- req_ready  out  NUM_REQ  one-hot acceptance; combinational.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_x  out  DW  latched x operand.
- eng_y  out  DW  latched y operand.
- eng_abort  out  1  one-cycle abort pulse to the engine.
- eng_done  in  1  engine completion pulse.
- eng_result  in  DW+1  engine result; valid when eng_done=1.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_data  out  DW+1  result.
- rsp_err  out  1  response produced by the watchdog.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset values: state=IDLE, rr_ptr=0, eng_start=0, eng_abort=0, eng_x=0, eng_y=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0.
- IDLE, arbitration: the winner is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
- IDLE, accept: req_ready[winner]=1 in the same cycle; the handshake completes that cycle.
  - Latch eng_x/eng_y from the winner's slice; latch rsp_id=winner.
  - Set rr_ptr=(winner+1) mod NUM_REQ; next state ISSUE.
- IDLE, no request: with no valid requester, req_ready=0 and the FSM stays in IDLE.
- req_ready is 0 in every state except IDLE.
- ISSUE: eng_start=1 for exactly this cycle; next state WAIT.
- WAIT: stay until eng_done=1, then capture rsp_data=eng_result and rsp_err=0; next state RESP.
- eng_done is sampled only in WAIT; in any other state it is ignored.
- RESP: rsp_valid=1. rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1.
  - On the handshake cycle, next state is IDLE and rsp_valid clears next cycle.
- Latency: request accept to rsp_valid = 2 cycles plus engine latency. A new accept is possible on the cycle after the response handshake.
- A requester that drops req_valid before acceptance loses its turn; no state is kept for it.
- Zero operands pass through unchanged; the engine result is forwarded as-is and no saturation is applied.
- Reset asserted mid-operation: return to the reset values on the next edge. The in-flight operation is discarded and no response is produced.

Optional Feature:
- Macro: HYP_SCHED_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no eng_done, pulse eng_abort=1 for one cycle and go to RESP with rsp_data=0, rsp_err=1.
  - eng_done arriving in the same cycle as the timeout wins: normal result, no abort.
- Undefined: no counter is built; eng_abort and rsp_err are tied 0 and WAIT waits indefinitely. Ports are present in both builds.

Test Plan:
- Single requester: req 0 with x=3, y=4; bench engine returns after 5 cycles -> rsp_id=0, rsp_data=5. Check eng_start is exactly 1 cycle and the rsp latency is 7 cycles.
- All four valid, operands (7,24), (10,15), (8,6), (255,255) -> responses in order id 0,1,2,3 with data 25, 18, 10, 360. A second round restarts at id 0.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_valid/rsp_id/rsp_data stable; req_ready stays 0 throughout.
- Stray eng_done pulses in IDLE and ISSUE -> no state change. Reset asserted during WAIT -> all outputs return to reset values next cycle and no response is produced.
- With HYP_SCHED_TIMEOUT_EN and TIMEOUT=64: engine never completes -> eng_abort pulses at WAIT cycle 64, then rsp_err=1, rsp_data=0. Repeat with eng_done on cycle 64 -> normal result, no abort.

Source files
------------

// File: rtl/hyp_req_scheduler_if.sv
// Request, engine and response signals of the hypotenuse scheduler.
// The master modport is the scheduler's view; slave is the requester/engine/consumer view.
interface hyp_req_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2,
    parameter int DW      = 8
) ();
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*DW-1:0] req_x;
    logic [NUM_REQ*DW-1:0] req_y;
    logic [NUM_REQ-1:0]    req_ready;

    logic                  eng_start;
    logic [DW-1:0]         eng_x;
    logic [DW-1:0]         eng_y;
    logic                  eng_abort;
    logic                  eng_done;
    logic [DW:0]           eng_result;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [DW:0]           rsp_data;
    logic                  rsp_err;
    logic                  busy;

    modport master (
        input  req_valid, req_x, req_y, eng_done, eng_result, rsp_ready,
        output req_ready, eng_start, eng_x, eng_y, eng_abort,
               rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport slave (
        output req_valid, req_x, req_y, eng_done, eng_result, rsp_ready,
        input  req_ready, eng_start, eng_x, eng_y, eng_abort,
               rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/hyp_req_scheduler.sv
// Round-robin scheduler sharing one hypotenuse engine; accept-to-rsp_valid = 2 + engine cycles, one op in flight,
// response held until rsp_ready. HYP_SCHED_TIMEOUT_EN adds an engine watchdog (abort + rsp_err after TIMEOUT WAIT cycles).
module hyp_req_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2,
    parameter int DW      = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    hyp_req_scheduler_if.master  bus
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << IDW) < NUM_REQ || TIMEOUT < 1) begin : g_param_check
        $error("hyp_req_scheduler: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     rr_next;
    logic               win_found;
    logic [IDW-1:0]     win_idx;
    logic [DW-1:0]      win_x;
    logic [DW-1:0]      win_y;
    logic [NUM_REQ-1:0] req_ready_c;
    int                 cand;

    logic               eng_start_q;
    logic [DW-1:0]      eng_x_q;
    logic [DW-1:0]      eng_y_q;
    logic               rsp_valid_q;
    logic [IDW-1:0]     rsp_id_q;
    logic [DW:0]        rsp_data_q;
    logic               busy_q;

`ifdef HYP_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]      wait_cnt;
    logic               eng_abort_q;
    logic               rsp_err_q;
`endif

    // Walk downward so the last hit, i.e. the closest index at or above rr_ptr, wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (bus.req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        win_x       = bus.req_x[int'(win_idx)*DW +: DW];
        win_y       = bus.req_y[int'(win_idx)*DW +: DW];
        rr_next     = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        req_ready_c = '0;
        if (state == IDLE && win_found) begin
            req_ready_c[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            eng_start_q <= 1'b0;
            eng_x_q     <= '0;
            eng_y_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
`ifdef HYP_SCHED_TIMEOUT_EN
            wait_cnt    <= '0;
            eng_abort_q <= 1'b0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            eng_start_q <= 1'b0;
`ifdef HYP_SCHED_TIMEOUT_EN
            eng_abort_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (win_found) begin
                        eng_x_q     <= win_x;
                        eng_y_q     <= win_y;
                        rsp_id_q    <= win_idx;
                        rr_ptr      <= rr_next;
                        eng_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef HYP_SCHED_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    // A done in the final watchdog cycle still counts as a normal completion.
                    if (bus.eng_done) begin
                        rsp_data_q  <= bus.eng_result;
                        rsp_valid_q <= 1'b1;
`ifdef HYP_SCHED_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state       <= RESP;
                    end
`ifdef HYP_SCHED_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        eng_abort_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.eng_start = eng_start_q;
    assign bus.eng_x     = eng_x_q;
    assign bus.eng_y     = eng_y_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_q;
`ifdef HYP_SCHED_TIMEOUT_EN
    assign bus.eng_abort = eng_abort_q;
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.eng_abort = 1'b0;
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_hyp_req_scheduler.sv
// Scoreboard bench for hyp_req_scheduler: directed plan items then randomized traffic,
// checked against an arithmetic reference model with a behavioural engine.
module tb_hyp_req_scheduler;
    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int DW      = 8;
    localparam int TIMEOUT = 64;

    typedef struct {
        int id;
        int data;
        int err;
        int acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hyp_req_scheduler_if #(.NUM_REQ(N), .IDW(IDW), .DW(DW)) bus ();

    hyp_req_scheduler #(.NUM_REQ(N), .IDW(IDW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // knobs
    bit rand_stim = 0;
    int rsp_mode  = 0;   // 0 always ready, 1 random, 2 held low
    int fix_lat   = 3;   // 0 -> random engine latency
    bit stray_en  = 0;
    bit hang      = 0;

    // requester state
    bit            pend [N];
    bit            acc_flag [N];
    logic [DW-1:0] px [N];
    logic [DW-1:0] py [N];

    // reference model state
    exp_t          sb [$];
    int            rr      = 0;
    bit            m_busy  = 0;
    int            acc_cyc = -100;
    logic [DW-1:0] cur_x, cur_y;

    // engine state
    bit e_active  = 0;
    int e_left    = 0;
    int cur_lat   = 0;
    int abort_exp = -1;

    int log_id [$];
    int log_data [$];
    int expd [4] = '{25, 18, 10, 360};

    function automatic int hyp(input int x, input int y);
        int v, r;
        v = x * x + y * y;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic logic [DW-1:0] pick();
        int r;
        r = $urandom_range(0, 5);
        if (r == 0) return '0;
        if (r == 1) return '1;
        return DW'($urandom);
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input int x, input int y);
        pend[i] = 1'b1;
        px[i]   = DW'(x);
        py[i]   = DW'(y);
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((sb.size() != 0 || m_busy || any_pend()) && t < budget);
        if (t >= budget) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: not idle after %0d cycles, outstanding=%0d", name, t, sb.size());
        end
    endtask

    task automatic check_reset(input string name);
        chk({name, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({name, "_rsp_id"},    bus.rsp_id,    0);
        chk({name, "_rsp_data"},  bus.rsp_data,  0);
        chk({name, "_rsp_err"},   bus.rsp_err,   0);
        chk({name, "_busy"},      bus.busy,      0);
        chk({name, "_eng_start"}, bus.eng_start, 0);
        chk({name, "_eng_abort"}, bus.eng_abort, 0);
        chk({name, "_eng_x"},     bus.eng_x,     0);
        chk({name, "_eng_y"},     bus.eng_y,     0);
    endtask

    // requester and consumer drivers
    initial begin
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc_flag[i]) begin
                    pend[i]     = 1'b0;
                    acc_flag[i] = 1'b0;
                end else if (rand_stim && pend[i] && $urandom_range(0, 7) == 0) begin
                    pend[i] = 1'b0;
                end
                if (rand_stim && !pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    px[i]   = pick();
                    py[i]   = pick();
                end
                bus.req_valid[i]         = pend[i];
                bus.req_x[i*DW +: DW]    = px[i];
                bus.req_y[i*DW +: DW]    = py[i];
            end
            case (rsp_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = 1'($urandom_range(0, 1));
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    // reference model: arbitration, acceptance and expected responses
    initial begin
        int            w;
        logic [N-1:0]  exp_rdy;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (rst) begin
                rr      = 0;
                m_busy  = 0;
                acc_cyc = -100;
                sb.delete();
                for (int i = 0; i < N; i++) acc_flag[i] = 1'b0;
                continue;
            end
            w       = -1;
            exp_rdy = '0;
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && bus.req_valid[(rr + k) % N]) w = (rr + k) % N;
                end
            end
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("req_ready", bus.req_ready, exp_rdy);
            chk("busy", bus.busy, m_busy);
            if (w >= 0) begin
                e.id   = w;
                e.data = hang ? 0 : hyp(px[w], py[w]);
                e.err  = hang ? 1 : 0;
                e.acc  = cyc;
                sb.push_back(e);
                rr          = (w + 1) % N;
                m_busy      = 1'b1;
                acc_cyc     = cyc;
                cur_x       = px[w];
                cur_y       = py[w];
                acc_flag[w] = 1'b1;
            end else if (bus.rsp_valid && bus.rsp_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    // behavioural engine
    initial begin
        bus.eng_done   = 1'b0;
        bus.eng_result = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.eng_done = 1'b0;
            if (e_active) begin
                e_left--;
                if (e_left == 0) begin
                    bus.eng_done   = 1'b1;
                    bus.eng_result = (DW+1)'(hyp(bus.eng_x, bus.eng_y));
                    e_active       = 1'b0;
                end
            end else if (stray_en && $urandom_range(0, 3) == 0) begin
                bus.eng_done   = 1'b1;
                bus.eng_result = (DW+1)'($urandom);
            end
            @(negedge clk);
            if (rst) begin
                e_active  = 1'b0;
                abort_exp = -1;
                continue;
            end
            chk("eng_start", bus.eng_start, cyc == acc_cyc + 1);
            chk("eng_abort", bus.eng_abort, cyc == abort_exp);
            if (bus.eng_start) begin
                chk("eng_x", bus.eng_x, cur_x);
                chk("eng_y", bus.eng_y, cur_y);
                if (hang) begin
                    cur_lat   = TIMEOUT;
                    abort_exp = cyc + 1 + TIMEOUT;
                end else begin
                    cur_lat  = (fix_lat > 0) ? fix_lat : $urandom_range(1, 8);
                    e_active = 1'b1;
                    e_left   = cur_lat;
                end
            end
        end
    end

    // response monitor
    initial begin
        bit   pv, pr;
        int   pid, pdata, perr;
        exp_t e;
        pv = 0;
        pr = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 0;
                pr = 0;
                continue;
            end
            if (bus.rsp_valid) begin
                if (pv && !pr) begin
                    chk("rsp_id_stable",   bus.rsp_id,   pid);
                    chk("rsp_data_stable", bus.rsp_data, pdata);
                    chk("rsp_err_stable",  bus.rsp_err,  perr);
                end else if (!pv) begin
                    if (sb.size() == 0) chk("rsp_unexpected_valid", bus.rsp_valid, 0);
                    else                chk("rsp_latency", cyc - sb[0].acc, 2 + cur_lat);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected_handshake", bus.rsp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id",   bus.rsp_id,   e.id);
                    chk("rsp_data", bus.rsp_data, e.data);
                    chk("rsp_err",  bus.rsp_err,  e.err);
                    log_id.push_back(int'(bus.rsp_id));
                    log_data.push_back(int'(bus.rsp_data));
                end
            end
            pv    = bus.rsp_valid;
            pr    = bus.rsp_ready;
            pid   = int'(bus.rsp_id);
            pdata = int'(bus.rsp_data);
            perr  = int'(bus.rsp_err);
        end
    end

    // main sequence
    initial begin
        int t, nresp;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("init");
        @(posedge clk);
        #1 rst = 1'b0;

        // two full round-robin rounds
        log_id.delete();
        log_data.delete();
        for (int round = 0; round < 2; round++) begin
            @(negedge clk);
            set_req(0, 7, 24);
            set_req(1, 10, 15);
            set_req(2, 8, 6);
            set_req(3, 255, 255);
            wait_quiet(200, "rr_round");
        end
        chk("rr_count", log_id.size(), 8);
        for (int k = 0; k < log_id.size() && k < 8; k++) begin
            chk("rr_order_id", log_id[k], k % 4);
            chk("rr_order_data", log_data[k], expd[k % 4]);
        end

        // single requester, engine latency 5
        fix_lat = 5;
        set_req(0, 3, 4);
        wait_quiet(100, "single");
        chk("single_id", log_id[$], 0);
        chk("single_data", log_data[$], 5);

        // backpressure in RESP with competing requests
        fix_lat  = 3;
        rsp_mode = 2;
        set_req(1, 9, 12);
        t = 0;
        while (!bus.rsp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("bp_rsp_valid_seen", bus.rsp_valid, 1);
        set_req(0, 1, 1);
        set_req(3, 0, 0);
        repeat (10) @(negedge clk);
        chk("bp_rsp_valid_held", bus.rsp_valid, 1);
        rsp_mode = 0;
        wait_quiet(200, "backpressure");

        // reset while the engine is busy
        fix_lat = 12;
        set_req(2, 5, 12);
        t = 0;
        while (!e_active && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("mid_reset_in_wait", bus.busy, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset("mid_reset");
        nresp = log_id.size();
        repeat (30) @(negedge clk);
        chk("no_rsp_after_reset", log_id.size(), nresp);

        // randomized traffic with stray done pulses and random backpressure
        fix_lat   = 0;
        stray_en  = 1;
        rsp_mode  = 1;
        rand_stim = 1;
        repeat (4000) @(negedge clk);
        rand_stim = 0;
        stray_en  = 0;
        rsp_mode  = 0;
        wait_quiet(500, "random_drain");

`ifdef HYP_SCHED_TIMEOUT_EN
        hang = 1;
        set_req(2, 30, 40);
        wait_quiet(300, "timeout_hang");
        chk("timeout_data", log_data[$], 0);
        hang    = 0;
        fix_lat = TIMEOUT;
        set_req(1, 30, 40);
        wait_quiet(300, "timeout_edge_done");
        chk("timeout_edge_data", log_data[$], 50);
`endif

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
